// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing generator.
//
// Divides the board clock down to the pixel rate and walks a horizontal /
// vertical counter pair across the full raster, including blanking. Sync,
// visible-area and strobe outputs are registered on the same edge as the
// counters, so every output describes the coordinates presented with it.
//
// Optional feature macro: VGA_GAME_TICK_EN
//   defined   -> an 8-bit frame counter produces game_tick every GAME_DIV frames
//   undefined -> no frame counter is built and game_tick is tied to 0
//
// Ports:
//   clk        in   board clock (sole clock)
//   rst        in   synchronous active-high reset
//   pix_en     out  one-clk strobe per pixel step
//   h_cnt      out  pixel column, 0 .. H total - 1
//   v_cnt      out  line number, 0 .. V total - 1
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   valid      out  high inside the visible area
//   line_tick  out  one-clk pulse when h_cnt wraps to 0
//   frame_tick out  one-clk pulse when (h_cnt, v_cnt) wraps to (0, 0)
//   game_tick  out  one-clk pulse every GAME_DIV frames
module vga_timing_gen #(
  parameter int unsigned PIX_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned GAME_DIV  = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
  output logic       line_tick,
  output logic       frame_tick,
  output logic       game_tick
);

  localparam int unsigned CW       = 10;
  localparam int unsigned DW       = 4;
  localparam int unsigned FW       = 8;
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  logic [DW-1:0] div_q, div_d;
  logic          pix_en_q, pix_en_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          valid_q, valid_d;
  logic          line_q, line_d;
  logic          frame_q, frame_d;

  // Pixel divider, raster counters and the decodes of the counters' next values
  always_comb begin
    div_d    = div_q + 1'b1;
    pix_en_d = 1'b0;
    h_d      = h_q;
    v_d      = v_q;
    line_d   = 1'b0;
    frame_d  = 1'b0;

    if (div_q == DW'(PIX_DIV - 1)) begin
      div_d    = '0;
      pix_en_d = 1'b1;
    end

    if (pix_en_q) begin
      if (h_q == CW'(H_TOTAL - 1)) begin
        h_d    = '0;
        line_d = 1'b1;
        if (v_q == CW'(V_TOTAL - 1)) begin
          v_d     = '0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end

    // Decoded from next values so they line up with the registered counters
    hsync_d = ~((h_d >= CW'(HS_START)) && (h_d <= CW'(HS_END)));
    vsync_d = ~((v_d >= CW'(VS_START)) && (v_d <= CW'(VS_END)));
    valid_d = (h_d < CW'(H_VISIBLE)) && (v_d < CW'(V_VISIBLE));
  end

  // Timing state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      valid_q  <= 1'b1;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      valid_q  <= valid_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end

`ifdef VGA_GAME_TICK_EN
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          game_q, game_d;

  // Frame counter: fires on the frame strobe that completes GAME_DIV frames
  always_comb begin
    fcnt_d = fcnt_q;
    game_d = 1'b0;
    if (frame_d) begin
      if (fcnt_q == FW'(GAME_DIV - 1)) begin
        fcnt_d = '0;
        game_d = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Frame counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
      game_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      game_q <= game_d;
    end
  end

  assign game_tick = game_q;
`else
  // GAME_DIV has no function without the frame counter
  logic [FW-1:0] unused_game_div;
  assign unused_game_div = FW'(GAME_DIV);
  assign game_tick       = 1'b0;
`endif

  assign pix_en     = pix_en_q;
  assign h_cnt      = h_q;
  assign v_cnt      = v_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign valid      = valid_q;
  assign line_tick  = line_q;
  assign frame_tick = frame_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock.
- Drives the `h_cnt`/`v_cnt` pixel coordinates that all picture generators consume, plus `hsync`/`vsync`, a visible-area flag and per-line and per-frame strobes.
- Sits at the top of the display pipeline, upstream of the picture generators and the colour mux.
- Optionally produces the frame-locked `game_tick` that paces sprite and background scrolling.

## Interface
Parameters:
- `PIX_DIV`, 4 — clk cycles per pixel; 100 MHz / 4 = 25 MHz pixel rate; legal 1..16.
- `H_VISIBLE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48 — horizontal timing in pixels (total 800).
- `V_VISIBLE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33 — vertical timing in lines (total 525).
- `GAME_DIV`, 1 — frames per `game_tick`; legal 1..255; used only with `VGA_GAME_TICK_EN`.

Ports:
- `clk`  in  1  board clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `pix_en`  out  1  one-clk strobe marking each pixel step.
- `h_cnt`  out  10  pixel column, 0..799.
- `v_cnt`  out  10  line number, 0..524.
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `valid`  out  1  high while `h_cnt`<640 and `v_cnt`<480.
- `line_tick`  out  1  one-clk pulse when `h_cnt` wraps to 0.
- `frame_tick`  out  1  one-clk pulse when (`h_cnt`,`v_cnt`) wraps to (0,0).
- `game_tick`  out  1  one-clk pulse every `GAME_DIV` frames; tied 0 without the macro.

## Operation
- Divider `div` counts 0..`PIX_DIV`-1. `pix_en` is registered and is high in the clk cycle after `div` reaches `PIX_DIV`-1, giving exactly one clk high in every `PIX_DIV` clks. With `PIX_DIV`=1, `pix_en` is constantly high after reset.
- On a clk edge where `pix_en`=1:
  - `h_cnt` increments.
  - At `h_cnt`=799, `h_cnt` returns to 0 and `v_cnt` increments.
  - At `v_cnt`=524 with `h_cnt`=799, both return to 0.
- `hsync`, `vsync` and `valid` are registered on the same edge as the counters, from the counters' next values. They always match the `h_cnt`/`v_cnt` presented in the same cycle.
  - `hsync`=0 iff `h_cnt` is in [656,751].
  - `vsync`=0 iff `v_cnt` is in [490,491].
- `line_tick` is high for the single clk in which `h_cnt` has just become 0 by wrap. `frame_tick` additionally requires `v_cnt` to have just become 0. Both are 0 during every other clk of that pixel.
- Counter widths: `h_cnt` and `v_cnt` are 10 bits, `div` is 4 bits, the frame counter is 8 bits. Counts never exceed their totals; no overflow is possible.
- Reset applied mid-frame aborts the frame immediately. No `frame_tick` or `line_tick` is issued for the abort.

## Timing
- Reset values: `h_cnt`=0, `v_cnt`=0, `div`=0, `pix_en`=0, `hsync`=1, `vsync`=1, `valid`=1, `line_tick`=0, `frame_tick`=0, `game_tick`=0, frame counter=0.
- First `pix_en`: high in the `PIX_DIV`-th clk after the clk in which `rst` is sampled low. The counters move to (1,0) on that edge.
- Pixel period: `PIX_DIV` clks.
- Line period: 800·`PIX_DIV` clks (3,200 at default).
- Frame period: 420,000·`PIX_DIV` clks (1,680,000 at default).
- Output latency from a counter change to sync/valid: 0 cycles, since both are registered together.
- The strobes `line_tick`, `frame_tick` and `game_tick` coincide with the clk in which the wrapped counter value first appears.

## Configuration
- `VGA_GAME_TICK_EN` defined:
  - An 8-bit frame counter advances on each `frame_tick`.
  - `game_tick` pulses in the same clk as `frame_tick` when the counter equals `GAME_DIV`-1; the counter then returns to 0.
  - With `GAME_DIV`=1, `game_tick` equals `frame_tick`.
  - `rst` clears the counter.
- `VGA_GAME_TICK_EN` undefined:
  - No frame counter is built.
  - `game_tick` is constant 0.
  - All other behaviour is identical.

## Test plan
- Reset check: hold `rst` for 5 clks, release. Every output holds its reset value. `pix_en` first rises 4 clks after release, then repeats every 4 clks with a single-clk width.
- Horizontal timing: run one line with defaults.
  - `hsync` is low for exactly 96 pixels, (`h_cnt` 656..751).
  - `valid` is high for 640 pixels of each visible line.
  - `line_tick` pulses once per 3,200 clks.
- Vertical and frame timing: run 2 frames.
  - `vsync` is low only on lines 490–491.
  - `valid` is 0 on every pixel with `v_cnt`≥480.
  - `frame_tick` pulses are exactly 1,680,000 clks apart, each coinciding with `h_cnt`=0 and `v_cnt`=0.
- Reset mid-frame: assert `rst` at `h_cnt`=300, `v_cnt`=200 for 1 clk.
  - The next cycle shows (0,0) with sync high and no `frame_tick`.
  - Timing then restarts exactly as after a power-on reset.
- `PIX_DIV`=1: `pix_en` is constant high after reset, and the frame period is 420,000 clks.
- Game tick with `VGA_GAME_TICK_EN` defined and `GAME_DIV`=3:
  - `game_tick` coincides with every third `frame_tick`, i.e. every 5,040,000 clks.
  - With the macro undefined, `game_tick` stays 0 for 4 frames.
